// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I decode definitions:
//   - RV32I base opcode constants
//   - instruction field bit positions
//   - decode-stage flush FSM state encoding (RUN / BUBBLE)
//   - is_rv32i_opcode(): legality check of a 7-bit major opcode
// No ports; imported by decode_fifo and decode_stage.
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int INSTR_W = 32;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;
  localparam int IMM_LSB    = 7;
  localparam int IMM_MSB    = 31;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// -----------------------------------------------------------------------------
// decode_fifo
// Circular instruction buffer of DEPTH entries holding {instr, pc}.
// Pointers wrap explicitly from DEPTH-1 to 0 so any DEPTH (1..8) works.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clr                 flush: empties the buffer on the next rising edge
//   push / pop          enqueue wr_* / dequeue head (caller guarantees legality)
//   wr_instr, wr_pc     entry being written
//   head_instr, head_pc oldest entry (contents undefined when level==0)
//   level               current number of entries
// -----------------------------------------------------------------------------
module decode_fifo
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [INSTR_W-1:0]         wr_instr,
  input  logic [XLEN-1:0]            wr_pc,
  output logic [INSTR_W-1:0]         head_instr,
  output logic [XLEN-1:0]            head_pc,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH+1);

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0]    pc_mem    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset: stale slots are never visible because the
  // consumer gates outputs with level.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      instr_mem[wr_ptr_q] <= wr_instr;
      pc_mem[wr_ptr_q]    <= wr_pc;
    end
  end

  assign head_instr = instr_mem[rd_ptr_q];
  assign head_pc    = pc_mem[rd_ptr_q];
  assign level      = level_q;

endmodule

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Buffered RV32I decode stage: accepts fetched {instr, pc} over a
// valid/ready handshake, stores them in decode_fifo, and presents the head
// entry with its fields split out. A nop (flush) empties the buffer and
// holds the stage idle for FLUSH_BUBBLES cycles.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN adds output 'illegal'.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           fetch-side handshake
//   in_instr, in_pc             fetched instruction and its address
//   nop                         flush request
//   out_valid/out_ready         execute-side handshake
//   inst, pc                    head instruction/address (zero when !out_valid)
//   rr1, rr2, rw                rs1, rs2, rd fields
//   imm, opcode, funct3, funct7 raw instruction fields
//   level                       buffer occupancy
//   illegal                     (macro only) head opcode is not RV32I
// -----------------------------------------------------------------------------
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int DEPTH         = 2,
  parameter int FLUSH_BUBBLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  input  logic                       nop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                inst,
  output logic [XLEN-1:0]            pc,
  output logic [4:0]                 rr1,
  output logic [4:0]                 rr2,
  output logic [4:0]                 rw,
  output logic [24:0]                imm,
  output logic [6:0]                 opcode,
  output logic [2:0]                 funct3,
  output logic [6:0]                 funct7,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef DECODE_ILLEGAL_CHECK_EN
  ,
  output logic                       illegal
`endif
);

  localparam int LW = $clog2(DEPTH+1);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                push, pop;
  logic [INSTR_W-1:0]  head_instr;
  logic [XLEN-1:0]     head_pc;

  // Handshakes depend only on registered state, so out_ready never reaches
  // in_ready combinationally.
  assign in_ready  = (level < LW'(DEPTH)) && (state_q == RUN);
  assign out_valid = (level != '0) && (state_q == RUN);

  // A flush wins over any transfer on the same edge.
  assign push = in_valid && in_ready && !nop;
  assign pop  = out_valid && out_ready && !nop;

  decode_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (nop),
    .push       (push),
    .pop        (pop),
    .wr_instr   (in_instr),
    .wr_pc      (in_pc),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .level      (level)
  );

  // Bubbles read as an all-zero word so every field is zero too.
  assign inst   = out_valid ? head_instr : '0;
  assign pc     = out_valid ? head_pc    : '0;
  assign rr1    = inst[RS1_MSB:RS1_LSB];
  assign rr2    = inst[RS2_MSB:RS2_LSB];
  assign rw     = inst[RD_MSB:RD_LSB];
  assign imm    = inst[IMM_MSB:IMM_LSB];
  assign opcode = inst[OPCODE_MSB:OPCODE_LSB];
  assign funct3 = inst[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7 = inst[FUNCT7_MSB:FUNCT7_LSB];

  // Flush FSM: nop (re)loads the bubble counter; BUBBLE counts down to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (nop) begin
      cnt_d   = 3'(FLUSH_BUBBLES);
      state_d = (FLUSH_BUBBLES == 0) ? RUN : BUBBLE;
    end else if (state_q == BUBBLE) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_d == 3'd0) state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  assign illegal = out_valid &&
                   ((inst[1:0] != 2'b11) || !is_rv32i_opcode(opcode));
`endif

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Two instances: A (DEPTH=2, FLUSH_BUBBLES=1) and B (DEPTH=3, FLUSH_BUBBLES=2).
// Expected {instr,pc} pairs are queued when the fetch handshake is seen and
// popped when the execute handshake is seen.
// Optional macro: DECODE_ILLEGAL_CHECK_EN enables the illegal-opcode test.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  // Instance A
  logic        a_in_valid, a_in_ready, a_nop, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_inst, a_pc;
  logic [4:0]  a_rr1, a_rr2, a_rw;
  logic [24:0] a_imm;
  logic [6:0]  a_opcode, a_funct7;
  logic [2:0]  a_funct3;
  logic [1:0]  a_level;
  // Instance B
  logic        b_in_valid, b_in_ready, b_nop, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr, b_in_pc, b_inst, b_pc;
  logic [4:0]  b_rr1, b_rr2, b_rw;
  logic [24:0] b_imm;
  logic [6:0]  b_opcode, b_funct7;
  logic [2:0]  b_funct3;
  logic [1:0]  b_level;
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic        a_illegal, b_illegal;
`endif

  decode_stage #(.XLEN(32), .DEPTH(2), .FLUSH_BUBBLES(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc), .nop(a_nop),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .inst(a_inst), .pc(a_pc), .rr1(a_rr1), .rr2(a_rr2), .rw(a_rw),
    .imm(a_imm), .opcode(a_opcode), .funct3(a_funct3), .funct7(a_funct7),
    .level(a_level)
`ifdef DECODE_ILLEGAL_CHECK_EN
    , .illegal(a_illegal)
`endif
  );

  decode_stage #(.XLEN(32), .DEPTH(3), .FLUSH_BUBBLES(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .nop(b_nop),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .inst(b_inst), .pc(b_pc), .rr1(b_rr1), .rr2(b_rr2), .rw(b_rw),
    .imm(b_imm), .opcode(b_opcode), .funct3(b_funct3), .funct7(b_funct7),
    .level(b_level)
`ifdef DECODE_ILLEGAL_CHECK_EN
    , .illegal(b_illegal)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive idle inputs, pulse reset across one rising edge, release at a
  // falling edge. Returns just after that falling edge.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 0; a_in_instr = 0; a_in_pc = 0; a_nop = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_instr = 0; b_in_pc = 0; b_nop = 0; b_out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_in_ready: got %b expected 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_out_valid: got %b expected 0", a_out_valid); end
    n_cmp++; if (a_level !== 2'd0) begin n_fail++; $display("FAIL reset_a_level: got %0d expected 0", a_level); end
    n_cmp++; if ({a_inst, a_pc, a_imm, a_opcode} !== '0) begin n_fail++; $display("FAIL reset_a_data: got inst %h pc %h expected 0", a_inst, a_pc); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_in_ready: got %b expected 1", b_in_ready); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_out_valid: got %b expected 0", b_out_valid); end
    n_cmp++; if (b_level !== 2'd0) begin n_fail++; $display("FAIL reset_b_level: got %0d expected 0", b_level); end
  endtask

  task automatic test_basic();
    logic [63:0] e;
    apply_reset();
    a_in_valid = 1; a_in_instr = 32'h00500093; a_in_pc = 32'h0; a_out_ready = 1;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency: got out_valid %b expected 0", a_out_valid); end
    if (a_in_valid && a_in_ready) exp_q.push_back({a_in_instr, a_in_pc});
    @(negedge clk);
    // Second word enqueued on the same edge the first is dequeued.
    a_in_instr = 32'h00A00113; a_in_pc = 32'h4;
    #1;
    n_cmp++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", a_out_valid); end
    n_cmp++; if (a_rr1 !== 5'd0) begin n_fail++; $display("FAIL basic_rr1: got %0d expected 0", a_rr1); end
    n_cmp++; if (a_rr2 !== 5'd5) begin n_fail++; $display("FAIL basic_rr2: got %0d expected 5", a_rr2); end
    n_cmp++; if (a_rw !== 5'd1) begin n_fail++; $display("FAIL basic_rw: got %0d expected 1", a_rw); end
    n_cmp++; if (a_imm !== 25'h00A001) begin n_fail++; $display("FAIL basic_imm: got %h expected 00a001", a_imm); end
    n_cmp++; if (a_opcode !== 7'h13) begin n_fail++; $display("FAIL basic_opcode: got %h expected 13", a_opcode); end
    n_cmp++; if ({a_funct3, a_funct7} !== 10'd0) begin n_fail++; $display("FAIL basic_funct: got %h/%h expected 0/0", a_funct3, a_funct7); end
    if (a_out_valid && a_out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_sb1: got %h/%h expected nothing", a_inst, a_pc); end
      else begin e = exp_q.pop_front(); if ({a_inst, a_pc} !== e) begin n_fail++; $display("FAIL basic_sb1: got %h/%h expected %h/%h", a_inst, a_pc, e[63:32], e[31:0]); end end
    end
    if (a_in_valid && a_in_ready) exp_q.push_back({a_in_instr, a_in_pc});
    @(negedge clk);
    a_in_valid = 0;
    #1;
    n_cmp++; if (a_level !== 2'd1) begin n_fail++; $display("FAIL basic_level_push_pop: got %0d expected 1", a_level); end
    n_cmp++; if (a_rw !== 5'd2) begin n_fail++; $display("FAIL basic_rw2: got %0d expected 2", a_rw); end
    if (a_out_valid && a_out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_sb2: got %h/%h expected nothing", a_inst, a_pc); end
      else begin e = exp_q.pop_front(); if ({a_inst, a_pc} !== e) begin n_fail++; $display("FAIL basic_sb2: got %h/%h expected %h/%h", a_inst, a_pc, e[63:32], e[31:0]); end end
    end
    @(negedge clk);
    #1;
    n_cmp++; if ({a_out_valid, a_level, a_inst} !== '0) begin n_fail++; $display("FAIL basic_drain: got valid %b level %0d inst %h expected 0", a_out_valid, a_level, a_inst); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_sb_left: got %0d entries expected 0", exp_q.size()); end
  endtask

  task automatic test_full_flush();
    logic [31:0] w [3];
    int k;
    logic acc;
    w[0] = 32'h00100093; w[1] = 32'h00200113; w[2] = 32'h00300193;
    apply_reset();
    k = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      a_in_valid = 1; a_in_instr = w[k]; a_in_pc = 32'h100 + 32'(k * 4);
      #1;
      acc = a_in_ready;
      @(negedge clk);
      if (acc && k < 2) k++;
      else if (acc) begin n_cmp++; n_fail++; $display("FAIL full_overaccept: got accept at level %0d expected none", a_level); end
    end
    #1;
    n_cmp++; if (k !== 2) begin n_fail++; $display("FAIL full_accepted: got %0d expected 2", k); end
    n_cmp++; if (a_level !== 2'd2) begin n_fail++; $display("FAIL full_level: got %0d expected 2", a_level); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", a_in_ready); end
    n_cmp++; if (a_inst !== w[0] || a_pc !== 32'h100) begin n_fail++; $display("FAIL full_head: got %h/%h expected %h/00000100", a_inst, a_pc, w[0]); end
    // Flush with transfers on both sides requested in the same cycle.
    a_nop = 1; a_out_ready = 1;
    @(negedge clk);
    a_nop = 0;
    #1;
    n_cmp++; if (a_level !== 2'd0) begin n_fail++; $display("FAIL flush_level: got %0d expected 0", a_level); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", a_out_valid); end
    n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: got in_ready %b expected 0", a_in_ready); end
    n_cmp++; if (a_inst !== 32'h0) begin n_fail++; $display("FAIL flush_inst: got %h expected 0", a_inst); end
    @(negedge clk);
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_resume: got in_ready %b expected 1", a_in_ready); end
    n_cmp++; if (a_level !== 2'd0) begin n_fail++; $display("FAIL flush_level2: got %0d expected 0", a_level); end
    @(negedge clk);
    a_in_valid = 0;
    #1;
    n_cmp++; if (a_level !== 2'd1 || a_inst !== w[2] || a_pc !== 32'h108) begin n_fail++; $display("FAIL flush_refill: got level %0d %h/%h expected 1 %h/00000108", a_level, a_inst, a_pc, w[2]); end
  endtask

  task automatic test_bubble_reload();
    apply_reset();
    b_in_valid = 1; b_in_instr = 32'h00100093; b_in_pc = 32'h0;
    @(negedge clk);
    b_in_valid = 0; b_nop = 1;
    #1;
    n_cmp++; if (b_level !== 2'd1) begin n_fail++; $display("FAIL bub_prefill: got %0d expected 1", b_level); end
    @(negedge clk);
    #1;
    n_cmp++; if ({b_in_ready, b_out_valid, b_level} !== 4'b0) begin n_fail++; $display("FAIL bub_s1: got rdy %b vld %b lvl %0d expected 0 0 0", b_in_ready, b_out_valid, b_level); end
    @(negedge clk);
    b_nop = 0;
    #1;
    n_cmp++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL bub_s2: got %b expected 0", b_in_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL bub_reload: got %b expected 0", b_in_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL bub_resume: got %b expected 1", b_in_ready); end
  endtask

  task automatic test_stream();
    logic [63:0] e;
    logic [31:0] ei;
    int sent, got;
    apply_reset();
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      b_in_valid  = (sent < 10);
      b_in_instr  = {12'(sent * 37 + 1), 20'h00093};
      b_in_pc     = 32'h1000 + 32'(sent * 4);
      b_out_ready = cyc[0];
      #1;
      if (b_out_valid && b_out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL stream_sb: got %h/%h expected nothing", b_inst, b_pc); end
        else begin
          e = exp_q.pop_front();
          ei = e[63:32];
          if ({b_inst, b_pc} !== e) begin n_fail++; $display("FAIL stream_sb: got %h/%h expected %h/%h", b_inst, b_pc, e[63:32], e[31:0]); end
          n_cmp++;
          if ({b_rr1, b_rr2, b_rw, b_imm, b_opcode, b_funct3, b_funct7} !==
              {ei[19:15], ei[24:20], ei[11:7], ei[31:7], ei[6:0], ei[14:12], ei[31:25]}) begin
            n_fail++; $display("FAIL stream_fields: got rr2 %0d imm %h expected rr2 %0d imm %h", b_rr2, b_imm, ei[24:20], ei[31:7]);
          end
`ifdef DECODE_ILLEGAL_CHECK_EN
          n_cmp++; if (b_illegal !== 1'b0) begin n_fail++; $display("FAIL stream_illegal: got %b expected 0", b_illegal); end
`endif
        end
        got++;
      end
      if (b_in_valid && b_in_ready) begin exp_q.push_back({b_in_instr, b_in_pc}); sent++; end
      @(negedge clk);
    end
    b_in_valid = 0; b_out_ready = 0;
    n_cmp++; if (got !== 10) begin n_fail++; $display("FAIL stream_count: got %0d expected 10", got); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stream_left: got %0d entries expected 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    a_in_valid = 1; a_in_instr = 32'h00100093; a_in_pc = 32'h20;
    @(negedge clk);
    a_in_instr = 32'h00200113; a_in_pc = 32'h24;
    @(negedge clk);
    a_in_valid = 0;
    #1;
    n_cmp++; if (a_level !== 2'd2 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got level %0d vld %b expected 2 1", a_level, a_out_valid); end
    #2;
    rst = 1'b1;
    a_in_valid = 1; a_in_instr = 32'h00300193; a_in_pc = 32'h28;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid: got %b expected 0", a_out_valid); end
    n_cmp++; if ({a_inst, a_pc} !== 64'h0) begin n_fail++; $display("FAIL arst_data: got %h/%h expected 0/0", a_inst, a_pc); end
    n_cmp++; if (a_level !== 2'd0) begin n_fail++; $display("FAIL arst_level: got %0d expected 0", a_level); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (a_level !== 2'd0) begin n_fail++; $display("FAIL arst_release: got %0d expected 0", a_level); end
    a_in_valid = 0;
    @(negedge clk);
    #1;
    n_cmp++; if (a_level !== 2'd0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_after: got level %0d rdy %b expected 0 1", a_level, a_in_ready); end
  endtask

`ifdef DECODE_ILLEGAL_CHECK_EN
  task automatic test_illegal();
    apply_reset();
    #1;
    n_cmp++; if (a_illegal !== 1'b0) begin n_fail++; $display("FAIL ill_idle: got %b expected 0", a_illegal); end
    a_in_valid = 1; a_in_instr = 32'h0000007F; a_in_pc = 32'h40;
    @(negedge clk);
    a_in_valid = 0;
    #1;
    n_cmp++; if (a_illegal !== 1'b1 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_7f: got ill %b vld %b expected 1 1", a_illegal, a_out_valid); end
    apply_reset();
    a_in_valid = 1; a_in_instr = 32'h00000013; a_in_pc = 32'h44;
    @(negedge clk);
    a_in_valid = 0;
    #1;
    n_cmp++; if (a_illegal !== 1'b0 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_13: got ill %b vld %b expected 0 1", a_illegal, a_out_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full_flush();
    test_bubble_reload();
    test_stream();
    test_async_reset();
`ifdef DECODE_ILLEGAL_CHECK_EN
    test_illegal();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 2, legal 1..8: instruction buffer entries.
REQ-003 SHALL have parameter FLUSH_BUBBLES, default 1, legal 0..7: forced idle cycles after a flush.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1: fetch-side handshake.
REQ-007 SHALL have ports in_instr input 32, in_pc input XLEN: fetched instruction and its address.
REQ-008 SHALL have port nop  input  1  flush request: erase all buffered instructions.
REQ-009 SHALL have ports out_valid output 1, out_ready input 1: execute-side handshake.
REQ-010 SHALL have ports inst output 32, pc output XLEN: head-entry instruction and address.
REQ-011 SHALL have ports rr1, rr2, rw output 5 each: inst[19:15], inst[24:20], inst[11:7].
REQ-012 SHALL have ports imm output 25 (inst[31:7]), opcode output 7 (inst[6:0]), funct3 output 3 (inst[14:12]), funct7 output 7 (inst[31:25]).
REQ-013 SHALL have port level output clog2(DEPTH+1): current entry count.

Function
REQ-014 SHALL hold entries in a circular buffer of DEPTH slots; read/write pointers wrap from DEPTH-1 to 0 for non-power-of-two DEPTH.
REQ-015 SHALL enqueue {in_instr,in_pc} on a rising edge where in_valid && in_ready && !nop.
REQ-016 SHALL dequeue the head on a rising edge where out_valid && out_ready && !nop.
REQ-017 SHALL drive in_ready = (level < DEPTH) && state==RUN; no combinational path from out_ready to in_ready.
REQ-018 SHALL drive out_valid = (level != 0) && state==RUN.
REQ-019 SHALL drive inst, pc and all field outputs as zero whenever out_valid is 0 (bubble reads as all-zero word).
REQ-020 SHALL have minimum latency of one cycle: an instruction enqueued at edge N is first visible on outputs after edge N.
REQ-021 SHALL keep level unchanged on simultaneous enqueue and dequeue; enqueue when full is impossible by REQ-017.
REQ-022 SHALL implement states RUN and BUBBLE with a down-counter; nop at an edge clears all entries, sets level to 0, loads the counter with FLUSH_BUBBLES and enters BUBBLE (stays RUN if FLUSH_BUBBLES==0).
REQ-023 SHALL decrement the counter each BUBBLE cycle and return to RUN when it reaches 0; nop during BUBBLE reloads the counter.
REQ-024 SHALL give nop priority over simultaneous enqueue and dequeue; both are discarded.
REQ-025 SHALL keep head outputs stable while out_valid && !out_ready.

Reset
REQ-026 SHALL on rst clear pointers, level=0, state=RUN, counter=0, making in_ready=1, out_valid=0, all data outputs 0.
REQ-027 SHALL discard in-flight entries when rst asserts mid-operation, with no enqueue on the edge rst deasserts if rst still sampled high.

Configuration
REQ-028 SHALL, with DECODE_ILLEGAL_CHECK_EN defined, add output illegal 1: high when out_valid and opcode is not one of 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011, or inst[1:0]!=11.
REQ-029 SHALL, without DECODE_ILLEGAL_CHECK_EN, omit the illegal port and its logic entirely.

Structure
REQ-030 SHALL place RV32I opcode constants, field bit positions and the RUN/BUBBLE state encoding in shared package riscv_pkg.
REQ-031 SHALL implement the buffer as sub-module decode_fifo (storage, pointers, level); field extraction and flush FSM stay in decode_stage.

Verification
REQ-032 Reset then push 0x00500093 at pc 0x0 with out_ready=1 -> next cycle out_valid=1, rr1=0, rw=1, imm=0x00A001, opcode=0x13.
REQ-033 DEPTH=2, out_ready=0, push 3 words -> level=2, in_ready=0 after second push, third word held at source, head unchanged.
REQ-034 Full buffer, assert nop one cycle with FLUSH_BUBBLES=1 -> level=0, out_valid=0, in_ready=0 one cycle, then in_ready=1.
REQ-035 DEPTH=3, stream 10 words with out_ready toggling every cycle -> all 10 emerge in order with matching pc, pointers wrap without loss.
REQ-036 With DECODE_ILLEGAL_CHECK_EN, push 0x0000007F -> illegal=1 while out_valid; push 0x00000013 -> illegal=0.
REQ-037 Assert rst asynchronously mid-stream with level=2 -> outputs zero immediately without a clock edge, level=0 after release.
